alu_top: RTL and testbench
==========================

Name: alu_top

Overview:
- 8-bit signed (two's complement) arithmetic unit with a start/ready handshake.
- Operations: ADD, SUB, MUL and DIV.
- ADD/SUB finish in one cycle; MUL (radix-2 shift-add/Booth) and DIV (restoring) are iterative, one bit per cycle.
- Sits as a coprocessor beside the datapath; operands are latched at start and the result is held until the next start.

Parameters:
none (datapath width fixed at 8 bits, result 16 bits)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- operand_a  in  8  signed operand A (dividend for DIV)
- operand_b  in  8  signed operand B (divisor for DIV)
- operation  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- start  in  1  request; sampled only when idle
- result  out  16  operation result (format per op below)
- ready  out  1  level: result/flags valid
- overflow  out  1  error/overflow flag, valid with ready
- zero  out  1  high when result == 16'h0000, valid with ready

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset: state IDLE; result=0, ready=0, overflow=0, zero=0. Reset mid-operation aborts the operation with no partial result.
- States:
  - IDLE: waiting for start.
  - MUL_ITER: 8 cycles.
  - DIV_ITER: 8 cycles.
  - DIV_FIX: 1 cycle.
- Start acceptance:
  - On a clk edge N with start=1 in IDLE, latch operand_a, operand_b and operation, and clear ready.
  - Input changes after edge N are ignored.
  - start while busy is ignored; start=1 held in IDLE after completion restarts the operation.
- Completion: outputs update and ready rises at the edge after the last state. Values are then held, and ready stays 1, until the next accepted start.
- ADD:
  - Completes at edge N+1.
  - r8 = a+b mod 256; result = sign-extend(r8) to 16 bits.
  - overflow = signed overflow (operands same sign, r8 sign differs).
- SUB:
  - Same timing as ADD; r8 = a-b mod 256; result sign-extended.
  - overflow = operand signs differ and r8 sign differs from a.
- MUL:
  - Signed 8x8 -> 16-bit product, exact.
  - MUL_ITER runs edges N+1..N+8; ready at N+9.
  - overflow = 0.
- DIV:
  - Signed, quotient truncates toward zero; remainder takes the dividend's sign; result = {remainder[7:0], quotient[7:0]}.
  - Magnitudes are divided in DIV_ITER (N+1..N+8); sign fixup in DIV_FIX (N+9); ready at N+10.
  - b=0: skip iteration, complete at N+1 with overflow=1 and result = {a, 8'hFF}.
  - a=-128, b=-1: quotient 0x80, remainder 0, overflow=1.
- zero = (result == 16'h0000) for all operations, computed from the final result.
- ready never pulses within a single operation: it falls at the accept edge and rises once at completion.

Test Plan:
- Reset, then ADD a=5, b=3 -> one cycle after accept: ready=1, result=16'd8, overflow=0, zero=0.
- SUB 10-6 -> result=16'd4.
- SUB 5-5 -> result=0, zero=1.
- ADD 127+1 -> result=16'hFF80, overflow=1.
- MUL 7*6 -> ready 9 cycles after accept, result=16'd42.
- MUL -4*3 (a=8'hFC) -> result=16'hFFF4, overflow=0.
- DIV 20/4 -> result[7:0]=5, result[15:8]=0, ready 10 cycles after accept.
- DIV 17/5 -> result=16'h0203.
- DIV -7/2 -> quotient 8'hFD, remainder 8'hFF.
- DIV 25/0 -> ready one cycle after accept, overflow=1, result=16'h19FF.
- ADD -5+3 -> result[7:0]=8'hFE.
- Reset asserted during MUL -> ready=0 and result=0 immediately.
- start pulsed during DIV_ITER -> ignored; original quotient delivered.

Source files
------------

// File: rtl/alu_top.sv
// 8-bit signed arithmetic coprocessor: ADD/SUB in one cycle, MUL by radix-2 Booth,
// DIV by restoring division on magnitudes followed by a sign fixup.
module alu_top (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  operand_a,
    input  logic [7:0]  operand_b,
    input  logic [1:0]  operation,
    input  logic        start,
    output logic [15:0] result,
    output logic        ready,
    output logic        overflow,
    output logic        zero
);

    // Handshake: start is sampled only in IDLE; the accepting edge latches the
    // operands and drops ready, which rises once at completion and then holds
    // result/overflow/zero stable until the next accepted start.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        MUL_ITER = 3'd2,
        DIV_ITER = 3'd3,
        DIV_FIX  = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [1:0]  op_q;
    logic [2:0]  count;

    logic [8:0]  acc;
    logic [7:0]  mq;
    logic        q_1;

    logic [7:0]  rem;
    logic [7:0]  quo;
    logic [7:0]  dvs;
    logic        neg_q;
    logic        neg_r;
    logic        div_ovf;

    logic [7:0]  add_r8;
    logic [7:0]  sub_r8;
    logic        add_ovf;
    logic        sub_ovf;
    logic [15:0] add_res;
    logic [15:0] sub_res;
    logic [15:0] div0_res;
    logic [7:0]  mag_a;
    logic [7:0]  mag_b;
    logic [8:0]  m_ext;
    logic [8:0]  booth_sum;
    logic [15:0] mul_res;
    logic [8:0]  div_shift;
    logic [8:0]  div_diff;
    logic        div_ge;
    logic [7:0]  rem_next;
    logic [7:0]  quo_next;
    logic [7:0]  quo_signed;
    logic [7:0]  rem_signed;
    logic [15:0] div_res;

    always_comb begin
        add_r8   = a_q + b_q;
        sub_r8   = a_q - b_q;
        add_ovf  = (a_q[7] == b_q[7]) && (add_r8[7] != a_q[7]);
        sub_ovf  = (a_q[7] != b_q[7]) && (sub_r8[7] != a_q[7]);
        add_res  = {{8{add_r8[7]}}, add_r8};
        sub_res  = {{8{sub_r8[7]}}, sub_r8};
        div0_res = {a_q, 8'hFF};
        // -128 maps to 8'h80, which is the correct unsigned magnitude
        mag_a    = a_q[7] ? (8'd0 - a_q) : a_q;
        mag_b    = b_q[7] ? (8'd0 - b_q) : b_q;
    end

    // Booth step: 9-bit accumulator so that acc - (-128) cannot wrap
    always_comb begin
        m_ext = {b_q[7], b_q};
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        // product as it stands after the arithmetic shift of this step
        mul_res = {booth_sum, mq[7:1]};
    end

    always_comb begin
        div_shift = {rem, quo[7]};
        div_diff  = div_shift - {1'b0, dvs};
        div_ge    = (div_shift >= {1'b0, dvs});
        rem_next  = div_ge ? div_diff[7:0] : div_shift[7:0];
        quo_next  = {quo[6:0], div_ge};
        quo_signed = neg_q ? (8'd0 - quo) : quo;
        rem_signed = neg_r ? (8'd0 - rem) : rem;
        div_res    = {rem_signed, quo_signed};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 2'b00;
            count    <= 3'd0;
            acc      <= 9'h000;
            mq       <= 8'h00;
            q_1      <= 1'b0;
            rem      <= 8'h00;
            quo      <= 8'h00;
            dvs      <= 8'h00;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_ovf  <= 1'b0;
            result   <= 16'h0000;
            ready    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= operand_a;
                        b_q   <= operand_b;
                        op_q  <= operation;
                        ready <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    count <= 3'd0;
                    case (op_q)
                        OP_ADD: begin
                            result   <= add_res;
                            overflow <= add_ovf;
                            zero     <= (add_res == 16'h0000);
                            ready    <= 1'b1;
                            state    <= IDLE;
                        end
                        OP_SUB: begin
                            result   <= sub_res;
                            overflow <= sub_ovf;
                            zero     <= (sub_res == 16'h0000);
                            ready    <= 1'b1;
                            state    <= IDLE;
                        end
                        OP_MUL: begin
                            acc   <= 9'h000;
                            mq    <= a_q;
                            q_1   <= 1'b0;
                            state <= MUL_ITER;
                        end
                        default: begin
                            if (b_q == 8'h00) begin
                                result   <= div0_res;
                                overflow <= 1'b1;
                                zero     <= (div0_res == 16'h0000);
                                ready    <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                rem     <= 8'h00;
                                quo     <= mag_a;
                                dvs     <= mag_b;
                                neg_q   <= a_q[7] ^ b_q[7];
                                neg_r   <= a_q[7];
                                div_ovf <= (a_q == 8'h80) && (b_q == 8'hFF);
                                state   <= DIV_ITER;
                            end
                        end
                    endcase
                end
                MUL_ITER: begin
                    acc   <= {booth_sum[8], booth_sum[8:1]};
                    mq    <= {booth_sum[0], mq[7:1]};
                    q_1   <= mq[0];
                    count <= count + 3'd1;
                    if (count == 3'd7) begin
                        result   <= mul_res;
                        overflow <= 1'b0;
                        zero     <= (mul_res == 16'h0000);
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DIV_ITER: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 3'd1;
                    if (count == 3'd7) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    result   <= div_res;
                    overflow <= div_ovf;
                    zero     <= (div_res == 16'h0000);
                    ready    <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: hand-computed vectors, completion latency,
// reset abort during MUL and a start pulse ignored while dividing.
module tb_alu_top;

    logic        clk;
    logic        reset;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [1:0]  operation;
    logic        start;
    logic [15:0] result;
    logic        ready;
    logic        overflow;
    logic        zero;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];

    alu_top dut (
        .clk       (clk),
        .reset     (reset),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operation (operation),
        .start     (start),
        .result    (result),
        .ready     (ready),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, optionally pulse
    // start poke cycles after acceptance, then check latency and outputs.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input logic [15:0] exp_res,
                          input logic exp_ovf, input int poke);
        int cycles;
        logic [15:0] e;
        @(negedge clk);
        operation = op;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        operand_a = 8'($urandom_range(0, 255));
        operand_b = 8'($urandom_range(0, 255));
        operation = 2'($urandom_range(0, 3));
        check({tag, "_busy"}, 32'(ready), 32'd0);
        exp_q.push_back(exp_res);
        cycles = 0;
        while (!ready && cycles < 20) begin
            start = (poke != 0 && cycles == poke);
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, 32'(cycles), 32'(lat));
        check({tag, "_res"}, 32'(result), 32'(e));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_zero"}, 32'(zero), 32'(e == 16'h0000));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        operand_a = 8'h00;
        operand_b = 8'h00;
        operation = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("add_5_3",     2'b00, 8'd5,   8'd3,  1,  16'h0008, 1'b0, 0);
        run_op("sub_10_6",    2'b01, 8'd10,  8'd6,  1,  16'h0004, 1'b0, 0);
        run_op("sub_5_5",     2'b01, 8'd5,   8'd5,  1,  16'h0000, 1'b0, 0);
        run_op("add_127_1",   2'b00, 8'd127, 8'd1,  1,  16'hFF80, 1'b1, 0);
        run_op("add_m5_3",    2'b00, 8'hFB,  8'd3,  1,  16'hFFFE, 1'b0, 0);
        run_op("sub_m128_1",  2'b01, 8'h80,  8'd1,  1,  16'h007F, 1'b1, 0);
        run_op("mul_7_6",     2'b10, 8'd7,   8'd6,  9,  16'h002A, 1'b0, 0);
        run_op("mul_m4_3",    2'b10, 8'hFC,  8'd3,  9,  16'hFFF4, 1'b0, 0);
        run_op("mul_m128sq",  2'b10, 8'h80,  8'h80, 9,  16'h4000, 1'b0, 0);
        run_op("mul_m1_m1",   2'b10, 8'hFF,  8'hFF, 9,  16'h0001, 1'b0, 0);
        run_op("mul_0_5",     2'b10, 8'd0,   8'd5,  9,  16'h0000, 1'b0, 0);
        run_op("div_20_4",    2'b11, 8'd20,  8'd4,  10, 16'h0005, 1'b0, 0);
        run_op("div_17_5",    2'b11, 8'd17,  8'd5,  10, 16'h0203, 1'b0, 0);
        run_op("div_m7_2",    2'b11, 8'hF9,  8'd2,  10, 16'hFFFD, 1'b0, 0);
        run_op("div_25_0",    2'b11, 8'd25,  8'd0,  1,  16'h19FF, 1'b1, 0);
        run_op("div_m128_m1", 2'b11, 8'h80,  8'hFF, 10, 16'h0080, 1'b1, 0);
        run_op("div_m128_1",  2'b11, 8'h80,  8'd1,  10, 16'h0080, 1'b0, 0);
        run_op("div_poke",    2'b11, 8'd17,  8'd5,  10, 16'h0203, 1'b0, 3);

        // reset in the middle of a multiply clears everything at once
        @(negedge clk);
        operation = 2'b10;
        operand_a = 8'd3;
        operand_b = 8'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("post_rst_add", 2'b00, 8'd1, 8'd2, 1, 16'h0003, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
